tt_um_processor: RTL and testbench

//   Tiny 8-bit register-file processor in the TinyTapeout user-module wrapper.

---
 rtl/tt_proc_pkg.sv | 39 +++
 rtl/proc_alu.sv | 70 +++++++
 rtl/tt_um_processor.sv | 54 +++++
 tb/tb_tt_um_processor.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/tt_proc_pkg.sv
// Shared opcodes, instruction field positions and ALU result bundle
// for the tiny 8-bit register-file processor.
package tt_proc_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_MOV = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_OR  = 4'h6;
  localparam logic [3:0] OP_XOR = 4'h7;
  localparam logic [3:0] OP_NOT = 4'h8;
  localparam logic [3:0] OP_SHL = 4'h9;
  localparam logic [3:0] OP_SHR = 4'hA;
  localparam logic [3:0] OP_INC = 4'hB;
  localparam logic [3:0] OP_DEC = 4'hC;
  localparam logic [3:0] OP_ADC = 4'hD;
  localparam logic [3:0] OP_CMP = 4'hE;
  localparam logic [3:0] OP_OUT = 4'hF;

  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 4;
  localparam int RD_MSB  = 3;
  localparam int RD_LSB  = 2;
  localparam int RS_MSB  = 1;
  localparam int RS_LSB  = 0;

  typedef struct packed {
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       wr_reg;
    logic       wr_out;
    logic       upd_c;
    logic       upd_z;
  } alu_out_t;

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU: computes the result, new flags and which pieces of
// architectural state the current opcode is allowed to update.
module proc_alu
  import tt_proc_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] imm,
  input  logic       c_in,
  output alu_out_t   o
);

  logic [8:0] sum;

  always_comb begin
    o   = '0;
    sum = '0;
    case (opcode)
      OP_LDI: begin o.res = imm;   o.wr_reg = 1'b1; end
      OP_MOV: begin o.res = b;     o.wr_reg = 1'b1; end
      OP_AND: begin o.res = a & b; o.wr_reg = 1'b1; end
      OP_OR:  begin o.res = a | b; o.wr_reg = 1'b1; end
      OP_XOR: begin o.res = a ^ b; o.wr_reg = 1'b1; end
      OP_NOT: begin o.res = ~b;    o.wr_reg = 1'b1; end
      OP_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        o.res = sum[7:0]; o.c = sum[8]; o.upd_c = 1'b1; o.wr_reg = 1'b1;
      end
      // 9-bit subtraction: bit 8 is the borrow
      OP_SUB: begin
        sum = {1'b0, a} - {1'b0, b};
        o.res = sum[7:0]; o.c = sum[8]; o.upd_c = 1'b1; o.wr_reg = 1'b1;
      end
      OP_SHL: begin
        o.res = {b[6:0], 1'b0}; o.c = b[7]; o.upd_c = 1'b1; o.wr_reg = 1'b1;
      end
      OP_SHR: begin
        o.res = {1'b0, b[7:1]}; o.c = b[0]; o.upd_c = 1'b1; o.wr_reg = 1'b1;
      end
      OP_INC: begin
        sum = {1'b0, b} + 9'd1;
        o.res = sum[7:0]; o.c = sum[8]; o.upd_c = 1'b1; o.wr_reg = 1'b1;
      end
      OP_DEC: begin
        sum = {1'b0, b} - 9'd1;
        o.res = sum[7:0]; o.c = sum[8]; o.upd_c = 1'b1; o.wr_reg = 1'b1;
      end
      OP_ADC: begin
        sum = {1'b0, a} + {1'b0, b} + {8'b0, c_in};
        o.res = sum[7:0]; o.c = sum[8]; o.upd_c = 1'b1; o.wr_reg = 1'b1;
      end
      OP_CMP: begin
        sum = {1'b0, a} - {1'b0, b};
        o.c = sum[8]; o.z = (sum[7:0] == 8'h00);
        o.res = {6'b0, o.c, o.z};
        o.upd_c = 1'b1; o.upd_z = 1'b1; o.wr_out = 1'b1;
      end
      OP_OUT: begin o.res = b; o.wr_out = 1'b1; end
      default: ;
    endcase
    // every register-writing opcode also drives OUT and sets Z from its result
    if (o.wr_reg) begin
      o.wr_out = 1'b1;
      o.upd_z  = 1'b1;
      o.z      = (o.res == 8'h00);
    end
  end

endmodule

// File: rtl/tt_um_processor.sv
// TinyTapeout wrapper: 4x8 register file, C/Z flags and OUT register,
// executing one streamed instruction per enabled clock.
module tt_um_processor
  import tt_proc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [3:0][7:0] regs;
  logic            c_q, z_q;
  logic [7:0]      out_q;
  logic [3:0]      opcode;
  logic [1:0]      rd, rs;
  alu_out_t        alu;

  assign opcode = ui_in[OPC_MSB:OPC_LSB];
  assign rd     = ui_in[RD_MSB:RD_LSB];
  assign rs     = ui_in[RS_MSB:RS_LSB];

  proc_alu u_alu (
    .opcode (opcode),
    .a      (regs[rd]),
    .b      (regs[rs]),
    .imm    (uio_in),
    .c_in   (c_q),
    .o      (alu)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs  <= '0;
      c_q   <= 1'b0;
      z_q   <= 1'b0;
      out_q <= 8'h00;
    end else if (ena) begin
      if (alu.wr_reg) regs[rd] <= alu.res;
      if (alu.wr_out) out_q    <= alu.res;
      if (alu.upd_c)  c_q      <= alu.c;
      if (alu.upd_z)  z_q      <= alu.z;
    end
  end

  assign uo_out  = out_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_processor.sv
// Directed + randomized bench for tt_um_processor against an arithmetic
// reference model of the instruction set.
module tb_tt_um_processor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;

  int passed = 0;
  int total  = 0;

  int m_r[4];
  int m_c, m_z, m_out;

  tt_um_processor dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_c = 0; m_z = 0; m_out = 0;
  endtask

  // Reference semantics in plain integer arithmetic
  task automatic model_exec(input int op, input int rd, input int rs, input int imm);
    int a, b, r, full;
    bit wr;
    a = m_r[rd]; b = m_r[rs]; r = 0; wr = 1;
    case (op)
      0:  wr = 0;
      1:  r = imm;
      2:  r = b;
      3:  begin full = a + b;       r = full % 256; m_c = (full > 255); end
      4:  begin r = (a - b + 256) % 256; m_c = (a < b); end
      5:  r = a & b;
      6:  r = a | b;
      7:  r = a ^ b;
      8:  r = 255 - b;
      9:  begin r = (b * 2) % 256;  m_c = (b >= 128); end
      10: begin r = b / 2;          m_c = b % 2; end
      11: begin r = (b + 1) % 256;  m_c = (b == 255); end
      12: begin r = (b + 255) % 256; m_c = (b == 0); end
      13: begin full = a + b + m_c; r = full % 256; m_c = (full > 255); end
      14: begin wr = 0; m_c = (a < b); m_z = (a == b); m_out = m_c * 2 + m_z; end
      default: begin wr = 0; m_out = b; end
    endcase
    if (wr) begin
      m_r[rd] = r; m_out = r; m_z = (r == 0);
    end
  endtask

  task automatic exec(input int op, input int rd, input int rs, input int imm, input string tag);
    ena = 1'b1;
    ui_in = 8'(op * 16 + rd * 4 + rs);
    uio_in = 8'(imm);
    model_exec(op, rd, rs, imm);
    @(posedge clk); #1;
    check(tag, uo_out, 8'(m_out));
  endtask

  task automatic exec_k(input int op, input int rd, input int rs, input int imm,
                        input string tag, input logic [7:0] spec_val);
    exec(op, rd, rs, imm, tag);
    check({tag, "_spec"}, uo_out, spec_val);
  endtask

  initial begin
    model_reset();
    #2;
    check("reset_out", uo_out, 8'h00);
    check("tie_oe", uio_oe, 8'h00);
    check("tie_out", uio_out, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    exec_k(15, 0, 0, 0, "out_r0_after_reset", 8'h00);

    // load and add
    exec_k(1, 1, 0, 8'h05, "ldi_r1", 8'h05);
    exec_k(1, 2, 0, 8'h07, "ldi_r2", 8'h07);
    exec_k(3, 1, 2, 0, "add_r1_r2", 8'h0C);

    // carry chain
    exec(1, 3, 0, 8'h00, "ldi_r3_0");
    exec(1, 0, 0, 8'h00, "ldi_r0_0");
    exec(1, 1, 0, 8'hFF, "ldi_r1_ff");
    exec(1, 2, 0, 8'h01, "ldi_r2_01");
    exec_k(3, 1, 2, 0, "add_wrap", 8'h00);
    exec_k(13, 3, 0, 0, "adc_carry_in", 8'h01);

    // compare
    exec(1, 0, 0, 8'h10, "ldi_r0_10");
    exec(1, 1, 0, 8'h10, "ldi_r1_10");
    exec_k(14, 0, 1, 0, "cmp_equal", 8'h01);
    exec(1, 1, 0, 8'h20, "ldi_r1_20");
    exec_k(14, 0, 1, 0, "cmp_borrow", 8'h02);

    // shifts and unary
    exec(1, 2, 0, 8'h81, "ldi_r2_81");
    exec_k(9, 3, 2, 0, "shl", 8'h02);
    exec_k(10, 3, 2, 0, "shr", 8'h40);
    exec_k(8, 0, 2, 0, "not", 8'h7E);
    exec_k(12, 1, 1, 0, "dec_rd_eq_rs", 8'h1F);
    exec_k(4, 1, 1, 0, "sub_self", 8'h00);
    exec_k(12, 1, 1, 0, "dec_zero", 8'hFF);
    exec_k(13, 0, 0, 0, "adc_self_carry", 8'hFD);

    // hold with ena low
    ena = 1'b0;
    ui_in = 8'h36;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_out", uo_out, 8'(m_out));
    end
    exec(15, 0, 0, 0, "hold_r0");
    exec(15, 0, 1, 0, "hold_r1");
    exec(15, 0, 2, 0, "hold_r2");
    exec(15, 0, 3, 0, "hold_r3");

    // async reset between edges
    ui_in = 8'h36; ena = 1'b1;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset_out", uo_out, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    exec(15, 0, 1, 0, "post_reset_r1");
    exec(13, 2, 3, 0, "post_reset_adc");

    // randomized stream
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(7) == 0) begin
        ena = 1'b0;
        ui_in = 8'($urandom);
        uio_in = 8'($urandom);
        @(posedge clk); #1;
        check("rand_hold", uo_out, 8'(m_out));
      end else begin
        exec(int'($urandom_range(15)), int'($urandom_range(3)), int'($urandom_range(3)),
             int'($urandom_range(255)), "rand_exec");
      end
      if (n % 100 == 99) begin
        for (int r = 0; r < 4; r++) exec(15, 0, r, 0, "rand_dump");
        check("rand_tie_oe", uio_oe, 8'h00);
        check("rand_tie_out", uio_out, 8'h00);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
